// File: rtl/rf_alu_sequencer_pkg.sv
// Shared definitions for the register-file read-modify-write sequencer:
// FSM state encodings and default widths.
package rf_alu_sequencer_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/rf_alu_sequencer_adder.sv
// Ripple-free behavioural adder with carry-in and carry-out; subtraction is
// done by the caller feeding an inverted operand2 and cin=1.
module rf_alu_sequencer_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  always_comb begin
    {cout, result} = {1'b0, operand1} + {1'b0, operand2} + {{DATA_W{1'b0}}, cin};
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Command-driven read-modify-write engine: reads rs1/rs2, adds or subtracts,
// writes rd. Optional overflow trap enabled by defining RF_SEQ_OVF_TRAP_EN.
module rf_alu_sequencer
  import rf_alu_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              cmd_sub,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_result,
  output logic              done_cout,
  output logic              busy
`ifdef RF_SEQ_OVF_TRAP_EN
  ,
  output logic              ovf_err
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, waddr_q, waddr_d;
  logic                sub_q, sub_d, cin_q, cin_d, cout_q, cout_d;
  logic                hold_cout_q, hold_cout_d;
  logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [DATA_W-1:0]   hold_res_q, hold_res_d;
  logic [DATA_W-1:0]   sum;
  logic                sum_cout;
  logic                in_wb;
  logic                accept;
  logic                trap;
`ifdef RF_SEQ_OVF_TRAP_EN
  logic                ovf_q, ovf_d, ovf_err_q, ovf_err_d;
`endif

  rf_alu_sequencer_adder #(.DATA_W(DATA_W)) u_adder (
    .operand1 (op1_q),
    .operand2 (op2_q),
    .cin      (cin_q),
    .result   (sum),
    .cout     (sum_cout)
  );

  assign in_wb  = (state_q == S_WB);
  assign accept = cmd_valid && (state_q == S_IDLE);

`ifdef RF_SEQ_OVF_TRAP_EN
  assign trap    = ovf_q;
  assign ovf_err = ovf_err_q | (in_wb & ovf_q);
`else
  assign trap    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    sub_d       = sub_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    cin_d       = cin_q;
    res_d       = res_q;
    cout_d      = cout_q;
    hold_res_d  = hold_res_q;
    hold_cout_d = hold_cout_q;
    waddr_d     = waddr_q;
`ifdef RF_SEQ_OVF_TRAP_EN
    ovf_d       = ovf_q;
    ovf_err_d   = ovf_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rs1_d   = cmd_rs1;
          rs2_d   = cmd_rs2;
          rd_d    = cmd_rd;
          sub_d   = cmd_sub;
          state_d = S_READ;
`ifdef RF_SEQ_OVF_TRAP_EN
          ovf_err_d = 1'b0;
`endif
        end
      end
      S_READ: begin
        op1_d   = rf_rdata1;
        op2_d   = sub_q ? ~rf_rdata2 : rf_rdata2;
        cin_d   = sub_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = sum;
        cout_d  = sum_cout;
        state_d = S_WB;
`ifdef RF_SEQ_OVF_TRAP_EN
        // op2 is already sub-adjusted, so one rule covers add and subtract
        ovf_d = (op1_q[DATA_W-1] == op2_q[DATA_W-1]) && (sum[DATA_W-1] != op1_q[DATA_W-1]);
`endif
      end
      S_WB: begin
        hold_res_d  = res_q;
        hold_cout_d = cout_q;
        waddr_d     = rd_q;
        state_d     = S_IDLE;
`ifdef RF_SEQ_OVF_TRAP_EN
        ovf_err_d   = ovf_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      sub_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      cin_q       <= 1'b0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      hold_res_q  <= '0;
      hold_cout_q <= 1'b0;
      waddr_q     <= '0;
`ifdef RF_SEQ_OVF_TRAP_EN
      ovf_q       <= 1'b0;
      ovf_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      sub_q       <= sub_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      cin_q       <= cin_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      hold_res_q  <= hold_res_d;
      hold_cout_q <= hold_cout_d;
      waddr_q     <= waddr_d;
`ifdef RF_SEQ_OVF_TRAP_EN
      ovf_q       <= ovf_d;
      ovf_err_q   <= ovf_err_d;
`endif
    end
  end

  // Strobes decode straight from state so an async reset drops them at once
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rf_raddr1   = rs1_q;
  assign rf_raddr2   = rs2_q;
  assign done_valid  = in_wb;
  assign rf_wen      = in_wb && (rd_q != '0) && !trap;
  assign rf_waddr    = in_wb ? rd_q   : waddr_q;
  assign rf_wdata    = in_wb ? res_q  : hold_res_q;
  assign done_result = in_wb ? res_q  : hold_res_q;
  assign done_cout   = in_wb ? cout_q : hold_cout_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer: models the regfile, drives a vector table and
// corner sequences, and scoreboards every done_valid pulse.
module tb_rf_alu_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RF_SEQ_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic          cmd_sub = 1'b0;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata, done_result;
  logic          rf_wen, done_valid, done_cout, busy;
`ifdef RF_SEQ_OVF_TRAP_EN
  logic          ovf_err;
`endif

  rf_alu_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rd      (cmd_rd),
    .cmd_sub     (cmd_sub),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .done_valid  (done_valid),
    .done_result (done_result),
    .done_cout   (done_cout),
    .busy        (busy)
`ifdef RF_SEQ_OVF_TRAP_EN
    ,
    .ovf_err     (ovf_err)
`endif
  );

  always #5 clk = ~clk;

  // Regfile model: async read, sync write, r0 writable; bench preload port
  logic [DW-1:0] rf [32] = '{default: '0};
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) begin
    if (rf_wen)      rf[rf_waddr] <= rf_wdata;
    else if (pre_en) rf[pre_addr] <= pre_data;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  typedef struct {
    logic [DW-1:0] res;
    logic          cout;
    logic          wen;
    logic [AW-1:0] waddr;
  } sb_t;
  sb_t sb_q[$];

  int cyc = 0, wen_cnt = 0, done_cnt = 0, done_cyc = 0;
  int acc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rf_wen) wen_cnt++;
    if (resetn && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (done_valid) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("done_result", done_result, e.res);
        chk("done_cout", {31'd0, done_cout}, {31'd0, e.cout});
        chk("wb_wen", {31'd0, rf_wen}, {31'd0, e.wen});
        chk("wb_wdata", rf_wdata, e.res);
        chk("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic sub);
    cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_sub = sub; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 12 && done_cnt < target; i++) tick();
    chk("done_timeout", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  typedef struct {
    logic [DW-1:0] a, b;
    logic [AW-1:0] rs1, rs2, rd;
    logic          sub;
    logic [DW-1:0] exp_res;
    logic          exp_cout;
    logic          ovf;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'd5,        32'd7,        5'd1,  5'd2,  5'd3,  1'b0, 32'd12,       1'b0, 1'b0};
    vecs[1] = '{32'd3,        32'd5,        5'd1,  5'd2,  5'd4,  1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{32'd5,        32'd3,        5'd1,  5'd2,  5'd4,  1'b1, 32'd2,        1'b1, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'd1,        5'd5,  5'd6,  5'd7,  1'b0, 32'd0,        1'b1, 1'b0};
    vecs[4] = '{32'd0,        32'd0,        5'd8,  5'd9,  5'd10, 1'b1, 32'd0,        1'b1, 1'b0};
    vecs[5] = '{32'h12345678, 32'h12345678, 5'd11, 5'd11, 5'd11, 1'b0, 32'h2468ACF0, 1'b0, 1'b0};
    vecs[6] = '{32'h80000000, 32'h80000000, 5'd12, 5'd13, 5'd14, 1'b0, 32'd0,        1'b1, 1'b1};
    vecs[7] = '{32'h7FFFFFFF, 32'd1,        5'd15, 5'd16, 5'd17, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[8] = '{32'h80000000, 32'd1,        5'd18, 5'd19, 5'd20, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[9] = '{32'd9,        32'd4,        5'd21, 5'd22, 5'd0,  1'b0, 32'd13,       1'b0, 1'b0};

    // Reset held with cmd_valid high: nothing may be accepted
    cmd_valid = 1'b1;
    tick(); tick(); tick();
    chk("rst_no_accept", acc_q.size(), 32'd0);
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
    cmd_valid = 1'b0;
    resetn = 1'b1;
    tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_result", done_result, 32'd0);
    chk("rst_raddr1", {27'd0, rf_raddr1}, 32'd0);
`ifdef RF_SEQ_OVF_TRAP_EN
    chk("rst_ovf_err", {31'd0, ovf_err}, 32'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      vec_t v;
      logic [DW-1:0] old;
      logic          wexp;
      int            w0, d0, a0;
      v = vecs[i];
      preload(v.rs1, v.a);
      preload(v.rs2, v.b);
      old  = rf[v.rd];
      wexp = (v.rd != 0) && !(OVF_EN && v.ovf);
      sb_q.push_back('{v.exp_res, v.exp_cout, wexp, v.rd});
      w0 = wen_cnt; d0 = done_cnt; a0 = acc_q.size();
      issue(v.rs1, v.rs2, v.rd, v.sub);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
`ifdef RF_SEQ_OVF_TRAP_EN
      chk($sformatf("v%0d_ovf_clr", i), {31'd0, ovf_err}, 32'd0);
`endif
      wait_done(d0 + 1);
      chk($sformatf("v%0d_latency", i), done_cyc - acc_q[a0], 32'd3);
      chk($sformatf("v%0d_wen_cnt", i), wen_cnt - w0, {31'd0, wexp});
      chk($sformatf("v%0d_rf", i), rf[v.rd], wexp ? v.exp_res : old);
      chk($sformatf("v%0d_hold", i), done_result, v.exp_res);
`ifdef RF_SEQ_OVF_TRAP_EN
      chk($sformatf("v%0d_ovf_err", i), {31'd0, ovf_err}, {31'd0, v.ovf});
`endif
    end

    // Back-to-back with valid held: second command reads the first's rd
    begin
      int a0, d0;
      preload(5'd1, 32'd10);
      preload(5'd2, 32'd20);
      a0 = acc_q.size(); d0 = done_cnt;
      sb_q.push_back('{32'd30, 1'b0, 1'b1, 5'd3});
      sb_q.push_back('{32'd50, 1'b0, 1'b1, 5'd5});
      issue(5'd1, 5'd2, 5'd3, 1'b0);
      cmd_rs1 = 5'd3; cmd_rs2 = 5'd2; cmd_rd = 5'd5; cmd_valid = 1'b1;
      for (int i = 0; i < 12 && acc_q.size() < a0 + 2; i++) tick();
      cmd_valid = 1'b0;
      chk("b2b_accepts", acc_q.size() - a0, 32'd2);
      if (acc_q.size() >= a0 + 2) chk("b2b_spacing", acc_q[a0 + 1] - acc_q[a0], 32'd4);
      wait_done(d0 + 2);
      chk("b2b_r3", rf[3], 32'd30);
      chk("b2b_r5", rf[5], 32'd50);
    end

    // Reset pulsed during EXEC: command dropped, no write
    begin
      int w0, d0;
      preload(5'd23, 32'd1);
      preload(5'd24, 32'd2);
      preload(5'd25, 32'hAA);
      w0 = wen_cnt; d0 = done_cnt;
      issue(5'd23, 5'd24, 5'd25, 1'b0);
      tick();
      resetn = 1'b0;
      #2;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_wen", {31'd0, rf_wen}, 32'd0);
      chk("mid_rst_done", {31'd0, done_valid}, 32'd0);
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_rst_no_write", rf[25], 32'hAA);
      chk("mid_rst_wen_cnt", wen_cnt - w0, 32'd0);
      chk("mid_rst_done_cnt", done_cnt - d0, 32'd0);
      chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    end

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
